// File: rtl/char_buffer_fill_engine.sv
// -----------------------------------------------------------------------------
// char_buffer_fill_engine
//
// Write-only fill engine for the VGA character buffer. On a start request it
// latches a region description and emits a stream of {col,row}-addressed
// writes, column fastest, then row. A wrEn/wrReady handshake lets the engine
// share the buffer write port with the CPU/terminal writer: a write is held
// stable until wrReady accepts it.
//
// Modes:
//   0 FULL     whole screen, data = fillChar
//   1 SEQ      whole screen, data = 0,1,2,... (wraps mod 2^DATA_W)
//   2 ROW_TAIL row startRow, cols startCol..NUM_COLS-1, data = fillChar
//   3 RECT     rows startRow..endRow, cols startCol..endCol, data = fillChar
//   4 EOS      from (startRow,startCol) to end of screen, data = fillChar;
//              only built when CHARBUF_FILL_EOS_EN is defined, otherwise
//              treated like the reserved modes
//   5-7        reserved: no writes, done pulse
//
// Ports:
//   clk       clock
//   resetn    asynchronous reset, active low
//   start     request pulse, sampled only in IDLE
//   mode      fill mode (see above)
//   startRow  first row            (ROW_TAIL/RECT/EOS)
//   startCol  first column         (ROW_TAIL/RECT/EOS)
//   endRow    last row, inclusive  (RECT)
//   endCol    last column, incl.   (RECT)
//   fillChar  fill character       (all modes except SEQ)
//   abort     cancel fill in progress, no done pulse
//   wrReady   buffer port accepts the current write this cycle
//   wrEn      write request
//   wrAddr    write address {col,row}
//   wrData    character to write
//   busy      engine not in IDLE
//   done      one-cycle completion pulse
//
// Configuration macro: CHARBUF_FILL_EOS_EN (enables mode 4 EOS).
// -----------------------------------------------------------------------------
module char_buffer_fill_engine #(
   parameter int NUM_COLS = 80,
   parameter int NUM_ROWS = 32,
   parameter int COL_W    = 7,
   parameter int ROW_W    = 5,
   parameter int DATA_W   = 7
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [2:0]             mode,
   input  logic [ROW_W-1:0]       startRow,
   input  logic [COL_W-1:0]       startCol,
   input  logic [ROW_W-1:0]       endRow,
   input  logic [COL_W-1:0]       endCol,
   input  logic [DATA_W-1:0]      fillChar,
   input  logic                   abort,
   input  logic                   wrReady,
   output logic                   wrEn,
   output logic [COL_W+ROW_W-1:0] wrAddr,
   output logic [DATA_W-1:0]      wrData,
   output logic                   busy,
   output logic                   done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [2:0] MODE_FULL     = 3'd0;
   localparam logic [2:0] MODE_SEQ      = 3'd1;
   localparam logic [2:0] MODE_ROW_TAIL = 3'd2;
   localparam logic [2:0] MODE_RECT     = 3'd3;
`ifdef CHARBUF_FILL_EOS_EN
   localparam logic [2:0] MODE_EOS      = 3'd4;
`endif

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NUM_COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NUM_ROWS - 1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
   localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

   logic [1:0]        state;
   logic [COL_W-1:0]  colCur;
   logic [ROW_W-1:0]  rowCur;
   logic [COL_W-1:0]  colWrap;   // column a row wrap returns to
   logic [COL_W-1:0]  colMax;
   logic [ROW_W-1:0]  rowMax;
   logic              seqMode;

   // Clamped request coordinates
   logic [COL_W-1:0]  scClamp;
   logic [COL_W-1:0]  ecClamp;
   logic [ROW_W-1:0]  srClamp;
   logic [ROW_W-1:0]  erClamp;

   // Region decode, loaded into the scan registers when start is taken
   logic [COL_W-1:0]  ldColStart;
   logic [COL_W-1:0]  ldColWrap;
   logic [COL_W-1:0]  ldColMax;
   logic [ROW_W-1:0]  ldRowStart;
   logic [ROW_W-1:0]  ldRowMax;
   logic              ldSeq;
   logic              ldEmpty;

   logic              lastWrite;

   assign wrAddr    = {colCur, rowCur};
   assign lastWrite = (colCur == colMax) && (rowCur == rowMax);

   // Compare at 32 bits so the clamp stays correct whatever the index widths.
   always_comb begin
      scClamp = (32'(startCol) >= NUM_COLS) ? COL_LAST : startCol;
      ecClamp = (32'(endCol)   >= NUM_COLS) ? COL_LAST : endCol;
      srClamp = (32'(startRow) >= NUM_ROWS) ? ROW_LAST : startRow;
      erClamp = (32'(endRow)   >= NUM_ROWS) ? ROW_LAST : endRow;
   end

   always_comb begin
      ldColStart = '0;
      ldColWrap  = '0;
      ldColMax   = '0;
      ldRowStart = '0;
      ldRowMax   = '0;
      ldSeq      = 1'b0;
      ldEmpty    = 1'b1;
      case (mode)
         MODE_FULL: begin
            ldColMax = COL_LAST;
            ldRowMax = ROW_LAST;
            ldEmpty  = 1'b0;
         end
         MODE_SEQ: begin
            ldColMax = COL_LAST;
            ldRowMax = ROW_LAST;
            ldSeq    = 1'b1;
            ldEmpty  = 1'b0;
         end
         MODE_ROW_TAIL: begin
            ldColStart = scClamp;
            ldColWrap  = scClamp;
            ldColMax   = COL_LAST;
            ldRowStart = srClamp;
            ldRowMax   = srClamp;
            ldEmpty    = 1'b0;
         end
         MODE_RECT: begin
            ldColStart = scClamp;
            ldColWrap  = scClamp;
            ldColMax   = ecClamp;
            ldRowStart = srClamp;
            ldRowMax   = erClamp;
            ldEmpty    = (erClamp < srClamp) || (ecClamp < scClamp);
         end
`ifdef CHARBUF_FILL_EOS_EN
         // First row starts at startCol, every following row at column 0.
         MODE_EOS: begin
            ldColStart = scClamp;
            ldColWrap  = '0;
            ldColMax   = COL_LAST;
            ldRowStart = srClamp;
            ldRowMax   = ROW_LAST;
            ldEmpty    = 1'b0;
         end
`endif
         default: begin
            ldEmpty = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         colCur  <= '0;
         rowCur  <= '0;
         colWrap <= '0;
         colMax  <= '0;
         rowMax  <= '0;
         seqMode <= 1'b0;
         wrEn    <= 1'b0;
         wrData  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wrEn <= 1'b0;
               done <= 1'b0;
               busy <= 1'b0;
               if (start && !abort) begin
                  colCur  <= ldColStart;
                  rowCur  <= ldRowStart;
                  colWrap <= ldColWrap;
                  colMax  <= ldColMax;
                  rowMax  <= ldRowMax;
                  seqMode <= ldSeq;
                  wrData  <= ldSeq ? '0 : fillChar;
                  busy    <= 1'b1;
                  if (ldEmpty) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ACTIVE;
                     wrEn  <= 1'b1;
                  end
               end
            end

            // wrEn is constantly high here, so wrReady alone marks acceptance.
            ACTIVE: begin
               if (abort) begin
                  state <= IDLE;
                  wrEn  <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else if (wrReady) begin
                  if (seqMode) begin
                     wrData <= wrData + DATA_ONE;
                  end
                  if (lastWrite) begin
                     state <= DONE;
                     wrEn  <= 1'b0;
                     done  <= 1'b1;
                  end else if (colCur == colMax) begin
                     colCur <= colWrap;
                     rowCur <= rowCur + ROW_ONE;
                  end else begin
                     colCur <= colCur + COL_ONE;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               wrEn  <= 1'b0;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               wrEn  <= 1'b0;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_buffer_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_char_buffer_fill_engine
//
// Scoreboard bench for char_buffer_fill_engine. Each directed test pushes its
// expected writes ({col,row}, data) into a queue before starting the engine;
// a monitor process pops and compares on every accepted write (wrEn&wrReady)
// and also checks that a write is held stable while wrReady is low. The
// stimulus process checks start-to-done latency, busy/done behaviour, abort
// and asynchronous reset.
//
// Latency convention: with start high in cycle 0, a fill of N writes and
// wrReady held high shows done in cycle N+1 (N+2 cycles counting both the
// start cycle and the done cycle). An empty fill shows done in cycle 1.
// -----------------------------------------------------------------------------
module tb_char_buffer_fill_engine;

   typedef struct {
      logic [11:0] addr;
      logic [6:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mode = '0;
   logic [4:0]  startRow = '0;
   logic [6:0]  startCol = '0;
   logic [4:0]  endRow = '0;
   logic [6:0]  endCol = '0;
   logic [6:0]  fillChar = '0;
   logic        abort = 1'b0;
   logic        wrReady = 1'b1;
   logic        wrEn;
   logic [11:0] wrAddr;
   logic [6:0]  wrData;
   logic        busy;
   logic        done;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   writeCount = 0;
   bit   toggleReady = 1'b0;

   char_buffer_fill_engine #(
      .NUM_COLS (80),
      .NUM_ROWS (32),
      .COL_W    (7),
      .ROW_W    (5),
      .DATA_W   (7)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .mode     (mode),
      .startRow (startRow),
      .startCol (startCol),
      .endRow   (endRow),
      .endCol   (endCol),
      .fillChar (fillChar),
      .abort    (abort),
      .wrReady  (wrReady),
      .wrEn     (wrEn),
      .wrAddr   (wrAddr),
      .wrData   (wrData),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void pushW(input int c, input int r, input int d);
      exp_t e;
      logic [31:0] cv, rv, dv;
      cv = c;
      rv = r;
      dv = d;
      e.addr = {cv[6:0], rv[4:0]};
      e.data = dv[6:0];
      sbq.push_back(e);
   endfunction

   // wrReady driver: constant high, or toggling every cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         wrReady = toggleReady ? ~wrReady : 1'b1;
      end
   end

   // Monitor / scoreboard checker.
   initial begin
      logic        holdValid;
      logic [11:0] holdAddr;
      logic [6:0]  holdData;
      exp_t        e;
      holdValid = 1'b0;
      holdAddr  = '0;
      holdData  = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            holdValid = 1'b0;
         end else begin
            if (wrEn && holdValid) begin
               check("hold_addr", {20'd0, wrAddr}, {20'd0, holdAddr});
               check("hold_data", {25'd0, wrData}, {25'd0, holdData});
            end
            if (wrEn && !wrReady) begin
               holdValid = 1'b1;
               holdAddr  = wrAddr;
               holdData  = wrData;
            end else begin
               holdValid = 1'b0;
            end
            if (wrEn && wrReady) begin
               writeCount++;
               if (sbq.size() == 0) begin
                  check("unexpected_write", {20'd0, wrAddr}, 32'hFFFF_FFFF);
               end else begin
                  e = sbq.pop_front();
                  check("wr_addr", {20'd0, wrAddr}, {20'd0, e.addr});
                  check("wr_data", {25'd0, wrData}, {25'd0, e.data});
               end
            end
         end
      end
   end

   task automatic launch(input logic [2:0] m, input logic [4:0] sr, input logic [6:0] sc,
                         input logic [4:0] er, input logic [6:0] ec, input logic [6:0] fc);
      @(posedge clk);
      #1;
      mode     = m;
      startRow = sr;
      startCol = sc;
      endRow   = er;
      endCol   = ec;
      fillChar = fc;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Run one fill whose expected writes are already queued.
   task automatic runFill(input string nm, input logic [2:0] m, input logic [4:0] sr,
                          input logic [6:0] sc, input logic [4:0] er, input logic [6:0] ec,
                          input logic [6:0] fc, input int expN, input bit timed);
      int cyc;
      bit got;
      launch(m, sr, sc, er, ec, fc);
      check({nm, "_busy"}, {31'd0, busy}, 32'd1);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1'b1;
      end
      if (!got) begin
         check({nm, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         if (timed) check({nm, "_done_cycle"}, cyc, expN + 1);
         check({nm, "_queue_drained"}, sbq.size(), 32'd0);
         @(negedge clk);
         check({nm, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
      end
      sbq.delete();
   endtask

   // Wait until n more writes have been seen, bounded.
   task automatic waitWrites(input string nm, input int base, input int n);
      int cyc;
      cyc = 0;
      while ((writeCount - base) < n && cyc < 4000) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      if ((writeCount - base) < n) check({nm, "_write_timeout"}, writeCount - base, n);
   endtask

   initial begin
      int base;
      int idx;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {10'd0, wrEn, wrAddr, wrData, busy, done}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // FULL, 0x20, wrReady high: 2560 writes, done in cycle 2561
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 80; c++)
            pushW(c, r, 32'h20);
      runFill("full", 3'd0, 5'd0, 7'd0, 5'd0, 7'd0, 7'h20, 2560, 1'b1);

      // SEQ with toggling wrReady: data 0..127 wrapping, fillChar ignored
      idx = 0;
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 80; c++) begin
            pushW(c, r, idx % 128);
            idx++;
         end
      toggleReady = 1'b1;
      base = writeCount;
      runFill("seq", 3'd1, 5'd3, 7'd4, 5'd0, 7'd0, 7'h55, 2560, 1'b0);
      check("seq_write_count", writeCount - base, 32'd2560);
      toggleReady = 1'b0;

      // ROW_TAIL row 5 col 70: cols 70..79
      for (int c = 70; c < 80; c++) pushW(c, 5, 32'h2E);
      runFill("row_tail", 3'd2, 5'd5, 7'd70, 5'd0, 7'd0, 7'h2E, 10, 1'b1);

      // ROW_TAIL col 90 clamps to 79: a single write
      pushW(79, 5, 32'h23);
      runFill("row_tail_clamp", 3'd2, 5'd5, 7'd90, 5'd0, 7'd0, 7'h23, 1, 1'b1);

      // RECT rows 2..3, cols 10..12
      pushW(10, 2, 32'h58); pushW(11, 2, 32'h58); pushW(12, 2, 32'h58);
      pushW(10, 3, 32'h58); pushW(11, 3, 32'h58); pushW(12, 3, 32'h58);
      runFill("rect", 3'd3, 5'd2, 7'd10, 5'd3, 7'd12, 7'h58, 6, 1'b1);

      // RECT endCol < startCol: empty, done in cycle 1
      runFill("rect_empty", 3'd3, 5'd2, 7'd10, 5'd3, 7'd9, 7'h58, 0, 1'b1);

      // Reserved mode 5: no writes
      runFill("reserved", 3'd5, 5'd0, 7'd0, 5'd0, 7'd0, 7'h41, 0, 1'b1);

      // Mode 4: EOS when built in, otherwise reserved
`ifdef CHARBUF_FILL_EOS_EN
      pushW(78, 30, 32'h2D);
      pushW(79, 30, 32'h2D);
      for (int c = 0; c < 80; c++) pushW(c, 31, 32'h2D);
      runFill("eos", 3'd4, 5'd30, 7'd78, 5'd0, 7'd0, 7'h2D, 82, 1'b1);
`else
      runFill("eos_reserved", 3'd4, 5'd30, 7'd78, 5'd0, 7'd0, 7'h2D, 0, 1'b1);
`endif

      // Abort after 100 writes: IDLE next cycle, no done pulse
      for (int i = 0; i < 100; i++) pushW(i % 80, i / 80, 32'h41);
      base = writeCount;
      launch(3'd0, 5'd0, 7'd0, 5'd0, 7'd0, 7'h41);
      waitWrites("abort", base, 100);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_idle", {29'd0, wrEn, busy, done}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort_no_done", {30'd0, done, wrEn}, 32'd0);
      end
      check("abort_write_count", writeCount - base, 32'd100);
      check("abort_queue_drained", sbq.size(), 32'd0);
      sbq.delete();

      // New start after abort runs normally
      for (int c = 75; c < 80; c++) pushW(c, 9, 32'h30);
      runFill("after_abort", 3'd2, 5'd9, 7'd75, 5'd0, 7'd0, 7'h30, 5, 1'b1);

      // Asynchronous reset mid-fill: outputs zero immediately
      for (int i = 0; i < 20; i++) pushW(i, 0, 32'h2A);
      base = writeCount;
      launch(3'd0, 5'd0, 7'd0, 5'd0, 7'd0, 7'h2A);
      waitWrites("reset", base, 20);
      resetn = 1'b0;
      #1;
      check("reset_mid_fill", {10'd0, wrEn, wrAddr, wrData, busy, done}, 32'd0);
      check("reset_queue_drained", sbq.size(), 32'd0);
      sbq.delete();
      @(negedge clk);
      resetn = 1'b1;

      // Fresh fill after reset
      pushW(1, 31, 32'h7F); pushW(2, 31, 32'h7F);
      runFill("after_reset", 3'd3, 5'd31, 7'd1, 5'd31, 7'd2, 7'h7F, 2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
